// File: rtl/axi4lite_mem_bridge.sv
// AXI4-Lite slave bridging to a single-cycle register-bank memory interface.
// Independent read and write FSMs, one outstanding transaction each; out-of-range accesses return SLVERR.
module axi4lite_mem_bridge #(
    parameter int REGISTER_N     = 16,
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 9,
    parameter int AXI_ADDR_WIDTH = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [REG_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [REG_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [REG_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          mem_wrSelect,
    output logic [REG_ADDR_WIDTH-1:0]     mem_wrAddr,
    output logic [REG_DATA_WIDTH-1:0]     mem_wrdin,
    output logic [REG_DATA_WIDTH/8-1:0]   mem_wrByteStrobe,
    output logic                          mem_rdSelect,
    output logic [REG_ADDR_WIDTH-1:0]     mem_rdAddr,
    output logic                          mem_rdStrobe,
    input  logic [REG_DATA_WIDTH-1:0]     mem_rddout
);

    localparam int STRB_W = REG_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] HI_MASK =
        ~AXI_ADDR_WIDTH'((64'd1 << (REG_ADDR_WIDTH + 2)) - 64'd1);
    localparam logic [REG_ADDR_WIDTH:0] REG_LIMIT = (REG_ADDR_WIDTH + 1)'(REGISTER_N);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Out of range when any bit above the word index is set or the index exceeds the bank.
    function automatic logic addr_error(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (|(a & HI_MASK)) || ({1'b0, a[REG_ADDR_WIDTH+1:2]} >= REG_LIMIT);
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // Holds the AXI readies low until the first clock edge after reset release.
    logic ready_en;

    logic                      aw_done, w_done, w_err;
    logic [REG_ADDR_WIDTH-1:0] aw_idx;
    logic [REG_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;

    logic                      ar_done, r_err;
    logic [REG_ADDR_WIDTH-1:0] ar_idx;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_done && w_done) w_next = W_EXEC;
            W_EXEC:  w_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_done) r_next = R_EXEC;
            R_EXEC:  r_next = R_RESP;
            R_RESP:  if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s_axi_awready    = 1'b0;
        s_axi_wready     = 1'b0;
        s_axi_bvalid     = 1'b0;
        mem_wrSelect     = 1'b0;
        mem_wrByteStrobe = '0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = ready_en && !aw_done;
                s_axi_wready  = ready_en && !w_done;
            end
            W_EXEC: begin
                if (!w_err) begin
                    mem_wrSelect     = 1'b1;
                    mem_wrByteStrobe = wstrb_q;
                end
            end
            W_RESP:  s_axi_bvalid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        mem_rdSelect  = 1'b0;
        mem_rdStrobe  = 1'b0;
        case (r_state)
            R_IDLE:  s_axi_arready = ready_en && !ar_done;
            R_EXEC: begin
                mem_rdSelect = !r_err;
                mem_rdStrobe = !r_err;
            end
            R_RESP:  s_axi_rvalid = 1'b1;
            default: ;
        endcase
    end

    // Write datapath: capture AW/W independently, present to memory on entry to W_EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            w_err       <= 1'b0;
            aw_idx      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mem_wrAddr  <= '0;
            mem_wrdin   <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_done <= 1'b1;
                aw_idx  <= s_axi_awaddr[REG_ADDR_WIDTH+1:2];
                w_err   <= addr_error(s_axi_awaddr);
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_done  <= 1'b1;
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (w_state == W_IDLE && aw_done && w_done && !w_err) begin
                mem_wrAddr <= aw_idx;
                mem_wrdin  <= wdata_q;
            end
            if (w_state == W_EXEC) begin
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                s_axi_bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read datapath: bank data is combinational, so it is sampled at the end of R_EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_done     <= 1'b0;
            r_err       <= 1'b0;
            ar_idx      <= '0;
            mem_rdAddr  <= '0;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                ar_done <= 1'b1;
                ar_idx  <= s_axi_araddr[REG_ADDR_WIDTH+1:2];
                r_err   <= addr_error(s_axi_araddr);
            end
            if (r_state == R_IDLE && ar_done && !r_err) begin
                mem_rdAddr <= ar_idx;
            end
            if (r_state == R_EXEC) begin
                ar_done     <= 1'b0;
                s_axi_rdata <= r_err ? '0 : mem_rddout;
                s_axi_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_mem_bridge.sv
// Directed and randomized bench for axi4lite_mem_bridge against a transaction-level register model.
module tb_axi4lite_mem_bridge;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int IW   = 9;
    localparam int SW   = DW / 8;
    localparam int NREG = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic          mem_wrSelect;
    logic [IW-1:0] mem_wrAddr;
    logic [DW-1:0] mem_wrdin;
    logic [SW-1:0] mem_wrByteStrobe;
    logic          mem_rdSelect;
    logic [IW-1:0] mem_rdAddr;
    logic          mem_rdStrobe;
    logic [DW-1:0] mem_rddout;

    int checks   = 0;
    int failures = 0;

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    axi4lite_mem_bridge #(
        .REGISTER_N(NREG), .REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(IW), .AXI_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_wrSelect(mem_wrSelect), .mem_wrAddr(mem_wrAddr), .mem_wrdin(mem_wrdin),
        .mem_wrByteStrobe(mem_wrByteStrobe), .mem_rdSelect(mem_rdSelect), .mem_rdAddr(mem_rdAddr),
        .mem_rdStrobe(mem_rdStrobe), .mem_rddout(mem_rddout)
    );

    // Register bank environment plus memory-interface monitor (samples pre-edge values).
    logic [DW-1:0] bank [NREG] = '{default: '0};
    int            cyc = 0;
    int            wr_cnt = 0, rd_cnt = 0, rdsel_cnt = 0, stray = 0, wr_edge = 0, rd_edge = 0;
    logic [IW-1:0] wr_addr_seen = '0, rd_addr_seen = '0;
    logic [DW-1:0] wr_data_seen = '0;
    logic [SW-1:0] wr_strb_seen = '0;

    assign mem_rddout = (mem_rdAddr < IW'(NREG)) ? bank[mem_rdAddr[3:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wrSelect) begin
            wr_cnt       <= wr_cnt + 1;
            wr_edge      <= cyc;
            wr_addr_seen <= mem_wrAddr;
            wr_data_seen <= mem_wrdin;
            wr_strb_seen <= mem_wrByteStrobe;
            for (int b = 0; b < SW; b++)
                if (mem_wrByteStrobe[b] && mem_wrAddr < IW'(NREG))
                    bank[mem_wrAddr[3:0]][8*b +: 8] <= mem_wrdin[8*b +: 8];
        end
        if (mem_rdStrobe) begin
            rd_cnt       <= rd_cnt + 1;
            rd_edge      <= cyc;
            rd_addr_seen <= mem_rdAddr;
        end
        if (mem_rdSelect) rdsel_cnt <= rdsel_cnt + 1;
        if (!mem_wrSelect && mem_wrByteStrobe != '0) stray <= stray + 1;
        if (!mem_rdSelect && mem_rdStrobe) stray <= stray + 1;
    end

    // Reference model: registers as seen from the bus.
    logic [DW-1:0] exp_regs [NREG] = '{default: '0};

    function automatic logic model_err(input logic [AW-1:0] a);
        return int'(a >> 2) >= NREG;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (model_err(a)) return '0;
        return exp_regs[a[5:2]];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (!model_err(a))
            for (int b = 0; b < SW; b++)
                if (s[b]) exp_regs[a[5:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: entered and left just after a falling edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input int aw_delay, input int w_delay,
                            input int b_delay);
        logic aw_got, w_got, aw_fire, w_fire, err;
        int   hs, wc0, t;
        err = model_err(addr);
        aw_got = 1'b0;
        w_got  = 1'b0;
        hs     = 0;
        wc0    = wr_cnt;
        for (t = 0; t < 40 && !(aw_got && w_got); t++) begin
            s_axi_awaddr  = addr;
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_awvalid = !aw_got && t >= aw_delay;
            s_axi_wvalid  = !w_got && t >= w_delay;
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            if (aw_fire || w_fire) hs = cyc + 1;
            @(negedge clk);
            if (aw_fire) aw_got = 1'b1;
            if (w_fire) w_got = 1'b1;
            if (w_fire && !aw_got) check("wready_drop", s_axi_wready, 0);
            if (aw_fire && !w_got) check("awready_drop", s_axi_awready, 0);
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("aw_w_handshake", {aw_got, w_got}, 2'b11);
        t = 0;
        while (!s_axi_bvalid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("b_latency", cyc, hs + 2);
        check("wr_cycles", wr_cnt - wc0, err ? 0 : 1);
        if (!err) begin
            check("wr_addr", wr_addr_seen, addr[IW+1:2]);
            check("wr_data", wr_data_seen, data);
            check("wr_strb", wr_strb_seen, strb);
            check("wr_edge", wr_edge, hs + 1);
        end
        check("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
        for (int h = 0; h < b_delay; h++) begin
            @(negedge clk);
            check("bvalid_hold", {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready},
                  {1'b1, err ? 2'b10 : 2'b00, 2'b00});
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_done", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
        model_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int ar_delay, input int hold);
        logic          err, got;
        logic [DW-1:0] exp_d;
        int            hs, rc0, t;
        err   = model_err(addr);
        exp_d = model_read(addr);
        got   = 1'b0;
        hs    = 0;
        rc0   = rd_cnt;
        for (t = 0; t < 40 && !got; t++) begin
            s_axi_araddr  = addr;
            s_axi_arvalid = t >= ar_delay;
            if (s_axi_arvalid && s_axi_arready) begin
                hs  = cyc + 1;
                got = 1'b1;
            end
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        check("ar_handshake", got, 1);
        t = 0;
        while (!s_axi_rvalid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("r_latency", cyc, hs + 2);
        check("rd_strobes", rd_cnt - rc0, err ? 0 : 1);
        if (!err) begin
            check("rd_addr", rd_addr_seen, addr[IW+1:2]);
            check("rd_edge", rd_edge, hs + 1);
        end
        check("rdata", s_axi_rdata, exp_d);
        check("rresp", s_axi_rresp, err ? 2'b10 : 2'b00);
        for (int h = 0; h < hold; h++) begin
            s_axi_araddr  = 11'h004;
            s_axi_arvalid = 1'b1;
            @(negedge clk);
            check("rvalid_hold", {s_axi_rvalid, s_axi_arready, s_axi_rresp}, {2'b10, err ? 2'b10 : 2'b00});
            check("rdata_hold", s_axi_rdata, exp_d);
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("r_done", {s_axi_rvalid, s_axi_arready}, 2'b01);
        check("rd_no_extra", rd_cnt - rc0, err ? 0 : 1);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 2047));
        return AW'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [AW-1:0] a;
        int            wc0, rc0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        check("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check("rst_selects", {mem_wrSelect, mem_rdSelect, mem_rdStrobe, mem_wrByteStrobe}, '0);
        check("rst_resps", {s_axi_bresp, s_axi_rresp}, 4'b0000);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_mem_addr", {mem_wrAddr, mem_rdAddr}, 0);
        check("rst_mem_din", mem_wrdin, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // Directed: aligned AW/W, W-before-AW, read-back, out-of-range, backpressure
        do_write(11'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(11'h004, 32'hCAFE_1234, 4'h3, 3, 0, 1);
        do_write(11'h00C, 32'h12345678, 4'hF, 0, 2, 0);
        do_read(11'h00C, 0, 0);
        do_read(11'h040, 0, 0);
        do_write(11'h7FC, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        do_read(11'h008, 0, 5);
        do_read(11'h004, 1, 0);
        do_write(11'h000, 32'h5555_AAAA, 4'h0, 0, 0, 0);
        do_read(11'h03C, 0, 0);
        do_write(11'h03F, 32'hA1B2_C3D4, 4'hA, 0, 0, 0);
        do_read(11'h03D, 0, 1);

        // Same-register read and write executing together: read sees the old value
        fork
            do_write(11'h00C, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
            do_read(11'h00C, 0, 0);
        join
        do_read(11'h00C, 0, 0);

        // Reset while the write waits in W_RESP and the read is in R_EXEC
        s_axi_awaddr  = 11'h010;
        s_axi_wdata   = 32'h7777_0001;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_araddr  = 11'h010;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {s_axi_bvalid, mem_rdSelect}, 2'b11);
        model_write(11'h010, 32'h7777_0001, 4'hF);
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outputs", {s_axi_bvalid, s_axi_rvalid, mem_wrSelect, mem_rdSelect, mem_rdStrobe}, 5'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 5'b11100);
        check("rst_dropped_access", {rd_cnt - rc0, wr_cnt - wc0}, 0);
        do_read(11'h010, 0, 0);
        do_write(11'h014, 32'h2468_ACE0, 4'hC, 0, 1, 0);
        do_read(11'h014, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            a = pick_addr();
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, SW'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Final bank contents and interface hygiene
        for (int r = 0; r < NREG; r++) check($sformatf("bank_%0d", r), bank[r], exp_regs[r]);
        check("stray_strobes", stray, 0);
        check("rdsel_eq_strobe", rdsel_cnt, rd_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
